// File: rtl/y86_fetch_ctrl_if.sv
// Fetch-stage bundle: instruction-memory handshake, decoder feedback and
// the M/W redirect sources seen by the fetch controller.
interface y86_fetch_ctrl_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [47:0] imem_data_i;
    logic [47:0] inst_o;
    logic [31:0] f_pc_o;
    logic        f_valid_o;
    logic [3:0]  f_icode_i;
    logic [31:0] f_valC_i;
    logic [31:0] f_valP_i;
    logic        d_stall_i;
    logic        m_mispredict_i;
    logic [31:0] m_valA_i;
    logic        w_ret_i;
    logic [31:0] w_valM_i;
    logic [1:0]  stat_o;

    modport master (
        output imem_req_o, imem_addr_o, inst_o, f_pc_o, f_valid_o, stat_o,
        input  imem_ack_i, imem_data_i, f_icode_i, f_valC_i, f_valP_i,
        input  d_stall_i, m_mispredict_i, m_valA_i, w_ret_i, w_valM_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_o, f_pc_o, f_valid_o, stat_o,
        output imem_ack_i, imem_data_i, f_icode_i, f_valC_i, f_valP_i,
        output d_stall_i, m_mispredict_i, m_valA_i, w_ret_i, w_valM_i
    );
endinterface

// File: rtl/y86_fetch_ctrl.sv
// Y86 fetch sequencer: owns the PC, drives a multi-cycle imem and presents
// the fetched 48-bit window to the decoder, honouring stalls and redirects.
module y86_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input logic             clk,
    input logic             rst,
    y86_fetch_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_AOK = 2'd0;
    localparam logic [1:0] ST_HLT = 2'd1;
    localparam logic [1:0] ST_ADR = 2'd2;

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    typedef enum logic [2:0] {FETCH, WAIT, VALID, RETWAIT, HALTED} state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc, pc_nxt;
    logic            req, req_nxt;
    logic [31:0]     addr, addr_nxt;
    logic [47:0]     inst, inst_nxt;
    logic [31:0]     fpc, fpc_nxt;
    logic            fvalid, fvalid_nxt;
    logic [1:0]      stat, stat_nxt;
    logic            discard, discard_nxt;
    logic [TW-1:0]   timer, timer_nxt;

    logic            redirect;
    logic [31:0]     redirect_pc;

    // A retiring ret outranks a mispredict: it is the older instruction.
    assign redirect    = bus.w_ret_i | bus.m_mispredict_i;
    assign redirect_pc = bus.w_ret_i ? bus.w_valM_i : bus.m_valA_i;

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = addr;
    assign bus.inst_o      = inst;
    assign bus.f_pc_o      = fpc;
    assign bus.f_valid_o   = fvalid;
    assign bus.stat_o      = stat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            req     <= 1'b0;
            addr    <= RESET_PC;
            inst    <= 48'h0;
            fpc     <= RESET_PC;
            fvalid  <= 1'b0;
            stat    <= ST_AOK;
            discard <= 1'b0;
            timer   <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            req     <= req_nxt;
            addr    <= addr_nxt;
            inst    <= inst_nxt;
            fpc     <= fpc_nxt;
            fvalid  <= fvalid_nxt;
            stat    <= stat_nxt;
            discard <= discard_nxt;
            timer   <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        req_nxt     = req;
        addr_nxt    = addr;
        inst_nxt    = inst;
        fpc_nxt     = fpc;
        fvalid_nxt  = fvalid;
        stat_nxt    = stat;
        discard_nxt = discard;
        timer_nxt   = timer;

        if (redirect) begin
            pc_nxt     = redirect_pc;
            fvalid_nxt = 1'b0;
            stat_nxt   = ST_AOK;
        end

        unique case (state)
            FETCH: begin
                if (!redirect) begin
                    req_nxt   = 1'b1;
                    addr_nxt  = pc;
                    timer_nxt = '0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_ack_i) begin
                    req_nxt     = 1'b0;
                    timer_nxt   = '0;
                    discard_nxt = 1'b0;
                    if (redirect || discard) begin
                        state_nxt = FETCH;
                    end else begin
                        inst_nxt   = bus.imem_data_i;
                        fpc_nxt    = pc;
                        fvalid_nxt = 1'b1;
                        state_nxt  = VALID;
                    end
                end else if (redirect) begin
                    // Request address must stay stable until ack; drop its data later.
                    discard_nxt = 1'b1;
                    timer_nxt   = timer + TW'(1);
                end else if (timer >= TW'(TIMEOUT - 1)) begin
                    stat_nxt    = ST_ADR;
                    req_nxt     = 1'b0;
                    discard_nxt = 1'b0;
                    timer_nxt   = '0;
                    state_nxt   = HALTED;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            VALID: begin
                if (redirect) begin
                    state_nxt = FETCH;
                end else if (!bus.d_stall_i) begin
                    fvalid_nxt = 1'b0;
                    unique case (bus.f_icode_i)
                        I_HALT: begin
                            stat_nxt  = ST_HLT;
                            state_nxt = HALTED;
                        end
                        I_RET:          state_nxt = RETWAIT;
                        I_JXX, I_CALL: begin
                            pc_nxt    = bus.f_valC_i;
                            state_nxt = FETCH;
                        end
                        default: begin
                            pc_nxt    = bus.f_valP_i;
                            state_nxt = FETCH;
                        end
                    endcase
                end
            end
            RETWAIT, HALTED: begin
                if (redirect) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_y86_fetch_ctrl.sv
// Bench for y86_fetch_ctrl: table vectors, directed corner sequences and a
// randomized run checked against a fetch-stream reference model.
module tb_y86_fetch_ctrl;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    y86_fetch_ctrl_if bus ();

    y86_fetch_ctrl #(.RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [31:0] valC;
        logic [31:0] valP;
        bit          exp_req;
        logic [31:0] exp_addr;
        logic [1:0]  exp_stat;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.imem_ack_i     = 1'b0;
        bus.imem_data_i    = 48'h0;
        bus.d_stall_i      = 1'b0;
        bus.m_mispredict_i = 1'b0;
        bus.m_valA_i       = 32'h0;
        bus.w_ret_i        = 1'b0;
        bus.w_valM_i       = 32'h0;
        bus.f_icode_i      = 4'h1;
        bus.f_valC_i       = 32'h0;
        bus.f_valP_i       = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] exp, input string nm);
        int n = 0;
        while (!bus.imem_req_o && n < 20) begin
            tick();
            n++;
        end
        check({nm, "_req"}, 64'(bus.imem_req_o), 64'(1));
        check({nm, "_addr"}, 64'(bus.imem_addr_o), 64'(exp));
    endtask

    task automatic give_ack(input logic [47:0] d);
        bus.imem_ack_i  = 1'b1;
        bus.imem_data_i = d;
        tick();
        bus.imem_ack_i  = 1'b0;
    endtask

    task automatic set_dec(input logic [3:0] ic, input logic [31:0] c, input logic [31:0] p);
        bus.f_icode_i = ic;
        bus.f_valC_i  = c;
        bus.f_valP_i  = p;
    endtask

    // Synthetic program image: icode derived from address bits, low word = address.
    function automatic logic [47:0] mem_word(input logic [31:0] a);
        logic [2:0] h;
        logic [3:0] ic;
        h = a[2:0] ^ a[5:3] ^ a[8:6];
        case (h)
            3'd0: ic = 4'h1;
            3'd1: ic = 4'h3;
            3'd2: ic = 4'h7;
            3'd3: ic = 4'h8;
            3'd4: ic = 4'h6;
            3'd5: ic = 4'h9;
            3'd6: ic = a[9] ? 4'h0 : 4'h2;
            default: ic = 4'h5;
        endcase
        return {ic, 12'hABC, a};
    endfunction

    // Where the next instruction after the one at a must come from.
    function automatic logic [31:0] model_next(input logic [31:0] a);
        logic [47:0] w;
        w = mem_word(a);
        if (w[47:44] == 4'h7 || w[47:44] == 4'h8) return a + 32'd52;
        return a + 32'd5;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        int          n;
        int          lat;
        int          accepted;
        int          r;
        bit          blocked;
        logic [31:0] exp_pc;
        logic [1:0]  exp_stat;
        logic [47:0] w;

        vecs[0] = '{4'h3, 32'h10,        32'h6,  1'b1, 32'h6,        2'd0};
        vecs[1] = '{4'h7, 32'h40,        32'h5,  1'b1, 32'h40,       2'd0};
        vecs[2] = '{4'h8, 32'h80,        32'h5,  1'b1, 32'h80,       2'd0};
        vecs[3] = '{4'h1, 32'h0,         32'h1,  1'b1, 32'h1,        2'd0};
        vecs[4] = '{4'h7, 32'hFFFF_FFFC, 32'h5,  1'b1, 32'hFFFF_FFFC, 2'd0};
        vecs[5] = '{4'h9, 32'h0,         32'h1,  1'b0, 32'h0,        2'd0};
        vecs[6] = '{4'h0, 32'h0,         32'h1,  1'b0, 32'h0,        2'd1};

        clear_inputs();
        do_reset();
        check("rst_req",    64'(bus.imem_req_o), 64'(0));
        check("rst_valid",  64'(bus.f_valid_o),  64'(0));
        check("rst_inst",   64'(bus.inst_o),     64'(0));
        check("rst_fpc",    64'(bus.f_pc_o),     64'(0));
        check("rst_stat",   64'(bus.stat_o),     64'(0));

        // irmovl after a two-cycle memory latency, then a three-cycle stall.
        wait_req(32'h0, "irm_first");
        tick();
        tick();
        set_dec(4'h3, 32'h10, 32'h6);
        give_ack(48'h30F0_0000_0010);
        bus.d_stall_i = 1'b1;
        check("irm_valid", 64'(bus.f_valid_o), 64'(1));
        check("irm_fpc",   64'(bus.f_pc_o),    64'(0));
        check("irm_inst",  64'(bus.inst_o),    64'(48'h30F0_0000_0010));
        repeat (3) begin
            tick();
            check("stall_inst",  64'(bus.inst_o),     64'(48'h30F0_0000_0010));
            check("stall_valid", 64'(bus.f_valid_o),  64'(1));
            check("stall_noreq", 64'(bus.imem_req_o), 64'(0));
        end
        bus.d_stall_i = 1'b0;
        wait_req(32'h6, "stall_next");

        for (int i = 0; i < 7; i++) begin
            do_reset();
            wait_req(32'h0, "vec_first");
            set_dec(vecs[i].icode, vecs[i].valC, vecs[i].valP);
            give_ack({vecs[i].icode, 44'h0});
            check("vec_valid", 64'(bus.f_valid_o), 64'(1));
            tick();
            check("vec_accept", 64'(bus.f_valid_o), 64'(0));
            if (vecs[i].exp_req) begin
                wait_req(vecs[i].exp_addr, "vec_next");
            end else begin
                seen = 0;
                repeat (4) begin
                    tick();
                    if (bus.imem_req_o) seen = 1;
                end
                check("vec_noreq", 64'(seen), 64'(0));
            end
            check("vec_stat", 64'(bus.stat_o), 64'(vecs[i].exp_stat));
        end

        // Mispredict while the 0x40 request is outstanding.
        do_reset();
        wait_req(32'h0, "mis_first");
        set_dec(4'h7, 32'h40, 32'h5);
        give_ack(48'h7000_0000_0040);
        tick();
        wait_req(32'h40, "mis_jmp");
        bus.m_mispredict_i = 1'b1;
        bus.m_valA_i       = 32'h5;
        tick();
        bus.m_mispredict_i = 1'b0;
        check("mis_hold_req",  64'(bus.imem_req_o),  64'(1));
        check("mis_hold_addr", 64'(bus.imem_addr_o), 64'(32'h40));
        tick();
        give_ack(48'hDEAD_0000_0040);
        check("mis_drop_valid", 64'(bus.f_valid_o), 64'(0));
        check("mis_drop_inst",  64'(bus.inst_o),    64'(48'h7000_0000_0040));
        wait_req(32'h5, "mis_redir");
        set_dec(4'h1, 32'h0, 32'h6);
        give_ack(48'h1000_0000_0005);
        check("mis_valid", 64'(bus.f_valid_o), 64'(1));
        check("mis_fpc",   64'(bus.f_pc_o),    64'(32'h5));

        // RET at 0x20 waits for the W-stage return address.
        do_reset();
        wait_req(32'h0, "ret_first");
        set_dec(4'h7, 32'h20, 32'h5);
        give_ack(48'h7000_0000_0020);
        tick();
        wait_req(32'h20, "ret_fetch");
        set_dec(4'h9, 32'h0, 32'h21);
        give_ack(48'h9000_0000_0000);
        check("ret_fpc", 64'(bus.f_pc_o), 64'(32'h20));
        tick();
        seen = 0;
        repeat (5) begin
            tick();
            if (bus.imem_req_o || bus.f_valid_o) seen = 1;
        end
        check("ret_idle", 64'(seen), 64'(0));
        bus.w_ret_i  = 1'b1;
        bus.w_valM_i = 32'h100;
        tick();
        bus.w_ret_i  = 1'b0;
        wait_req(32'h100, "ret_resume");

        // HALT squashed by a mispredict.
        do_reset();
        wait_req(32'h0, "hlt_first");
        set_dec(4'h0, 32'h0, 32'h1);
        give_ack(48'h0000_0000_0000);
        tick();
        check("hlt_stat", 64'(bus.stat_o), 64'(1));
        seen = 0;
        repeat (4) begin
            tick();
            if (bus.imem_req_o) seen = 1;
        end
        check("hlt_noreq", 64'(seen), 64'(0));
        bus.m_mispredict_i = 1'b1;
        bus.m_valA_i       = 32'h8;
        tick();
        bus.m_mispredict_i = 1'b0;
        check("hlt_clear", 64'(bus.stat_o), 64'(0));
        wait_req(32'h8, "hlt_resume");

        // Redirect coinciding with ack, both sources at once: ret wins.
        do_reset();
        wait_req(32'h0, "both_first");
        bus.imem_ack_i     = 1'b1;
        bus.imem_data_i    = 48'h3000_0000_0000;
        bus.w_ret_i        = 1'b1;
        bus.w_valM_i       = 32'h30;
        bus.m_mispredict_i = 1'b1;
        bus.m_valA_i       = 32'h50;
        tick();
        clear_inputs();
        check("both_valid", 64'(bus.f_valid_o), 64'(0));
        wait_req(32'h30, "both_next");

        // Stale ack right after a reset that aborted a request.
        do_reset();
        wait_req(32'h0, "stale_first");
        do_reset();
        bus.imem_ack_i = 1'b1;
        tick();
        bus.imem_ack_i = 1'b0;
        check("stale_valid", 64'(bus.f_valid_o),  64'(0));
        check("stale_req",   64'(bus.imem_req_o), 64'(1));

        // Timeout: request drops after exactly TIMEOUT waiting cycles.
        do_reset();
        wait_req(32'h0, "to_first");
        n = 0;
        while (bus.imem_req_o && n < 3 * TIMEOUT) begin
            tick();
            n++;
        end
        check("to_cycles", 64'(n),              64'(TIMEOUT));
        check("to_stat",   64'(bus.stat_o),     64'(2));
        check("to_req",    64'(bus.imem_req_o), 64'(0));
        do_reset();
        check("to_rst_stat", 64'(bus.stat_o), 64'(0));
        wait_req(32'h0, "to_rst");

        // Randomized run against the fetch-stream model.
        do_reset();
        exp_pc   = 32'h0;
        exp_stat = 2'd0;
        blocked  = 1'b0;
        lat      = $urandom_range(0, 4);
        accepted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_stat", 64'(bus.stat_o), 64'(exp_stat));
            if (bus.f_valid_o) begin
                check("rnd_blocked", 64'(blocked),    64'(0));
                check("rnd_fpc",     64'(bus.f_pc_o), 64'(exp_pc));
                check("rnd_inst",    64'(bus.inst_o), 64'(mem_word(bus.f_pc_o)));
            end
            if (bus.imem_ack_i) begin
                bus.imem_ack_i = 1'b0;
            end else if (bus.imem_req_o) begin
                if (lat == 0) begin
                    bus.imem_ack_i  = 1'b1;
                    bus.imem_data_i = mem_word(bus.imem_addr_o);
                    lat = $urandom_range(0, 4);
                end else begin
                    lat--;
                end
            end
            w = bus.inst_o;
            set_dec(w[47:44], w[31:0] + 32'd52, w[31:0] + 32'd5);
            bus.d_stall_i      = ($urandom_range(0, 2) == 0);
            r                  = $urandom_range(0, 31);
            bus.w_ret_i        = (r == 0) || (r == 3);
            bus.m_mispredict_i = (r == 1) || (r == 3);
            bus.w_valM_i       = $urandom;
            bus.m_valA_i       = $urandom;
            if (bus.w_ret_i || bus.m_mispredict_i) begin
                exp_pc   = bus.w_ret_i ? bus.w_valM_i : bus.m_valA_i;
                blocked  = 1'b0;
                exp_stat = 2'd0;
            end else if (bus.f_valid_o && !bus.d_stall_i) begin
                accepted++;
                w = mem_word(exp_pc);
                if (w[47:44] == 4'h0) begin
                    blocked  = 1'b1;
                    exp_stat = 2'd1;
                end else if (w[47:44] == 4'h9) begin
                    blocked = 1'b1;
                end
                exp_pc = model_next(exp_pc);
            end
            tick();
        end
        check("rnd_progress", 64'(accepted > 100), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/y86_fetch_ctrl.md
Name: y86_fetch_ctrl

Overview:
- Sequences the Y86 fetch stage: owns the PC register, issues requests to a multi-cycle instruction memory and presents the returned 48-bit instruction window to the combinational fetch decoder.
- Selects the next PC from the decoder's predicted PC, an M-stage branch-mispredict redirect, or a W-stage ret redirect.
- Handles decode stalls, ret bubbles, halt and instruction-memory timeout.
- Sits between imem and the fetch decoder / F-D pipeline register.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- TIMEOUT, 16, max cycles waiting for imem_ack before the address-error halt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- imem_req_o  out  1  instruction read request, held until ack
- imem_addr_o  out  32  byte address of the request
- imem_ack_i  in  1  one-cycle pulse: imem_data_i valid
- imem_data_i  in  48  instruction bytes at imem_addr_o
- inst_o  out  48  registered instruction window to the decoder
- f_pc_o  out  32  PC of inst_o
- f_valid_o  out  1  inst_o/f_pc_o valid for the F-D register
- f_icode_i  in  4  decoded icode of inst_o
- f_valC_i  in  32  decoded valC
- f_valP_i  in  32  decoded valP
- d_stall_i  in  1  decode stalled; hold the current instruction
- m_mispredict_i  in  1  M stage: JXX not taken
- m_valA_i  in  32  fall-through PC for the mispredict redirect
- w_ret_i  in  1  W stage: RET retiring
- w_valM_i  in  32  return address
- stat_o  out  2  0 AOK, 1 HLT, 2 ADR (timeout)

Behaviour:
- Reset (rst=1 at clk edge), taking precedence over everything including an in-flight request:
  - state=FETCH, pc=RESET_PC, imem_req_o=0, f_valid_o=0, inst_o=48'h0, f_pc_o=RESET_PC, stat_o=0, discard=0, timer=0.
  - An imem_ack_i arriving after reset is ignored unless a new request is outstanding.
- States: FETCH, WAIT, VALID, RETWAIT, HALTED.
- FETCH:
  - Assert imem_req_o with imem_addr_o=pc; go to WAIT the same edge.
  - The request becomes visible the cycle after entering FETCH.
- WAIT:
  - imem_req_o=1, the timer increments each cycle.
  - On imem_ack_i with discard=0: inst_o<=imem_data_i, f_pc_o<=pc, f_valid_o<=1, timer<=0, go to VALID.
  - On imem_ack_i with discard=1: drop the data, clear discard, go to FETCH.
  - If the timer reaches TIMEOUT without an ack: stat_o<=2, imem_req_o<=0, go to HALTED.
- VALID (decoder outputs valid combinationally from inst_o):
  - If d_stall_i=1: hold inst_o, f_pc_o and f_valid_o.
  - Otherwise, on f_valid_o acceptance, by f_icode_i:
    - HALT (0): stat_o<=1, f_valid_o<=0, go to HALTED.
    - RET (9): f_valid_o<=0, go to RETWAIT.
    - JXX (7) or CALL (8): pc<=f_valC_i, go to FETCH.
    - Any other icode: pc<=f_valP_i, go to FETCH.
- RETWAIT: f_valid_o=0; wait for w_ret_i.
- Redirect priority: w_ret_i over m_mispredict_i over the predicted PC. A redirect is evaluated in every state, regardless of d_stall_i.
  - On redirect: pc<=w_valM_i or m_valA_i, f_valid_o<=0, stat_o<=0.
  - If in WAIT without ack this cycle: set discard=1 and stay in WAIT. The outstanding request completes and is discarded, then the new PC is fetched. imem_addr_o stays stable until ack.
  - If in WAIT with ack this cycle: drop the data and go to FETCH.
  - Otherwise: go to FETCH.
- HALTED:
  - imem_req_o=0, f_valid_o=0.
  - Left only by reset or a redirect, because a halt on a mispredicted path must be squashed.
  - A redirect clears stat_o to 0.
- imem_addr_o and imem_req_o are registered and must not change while req=1 and ack is not yet seen.
- PC arithmetic is 32-bit, wrap-around modulo 2^32, no error.

Test Plan:
- Reset, then ack after 2 cycles returning 48'h30F0_0000_0010 (irmovl): f_valid_o=1, f_pc_o=0; next request at addr 6.
- Hold d_stall_i=1 for 3 cycles while VALID: inst_o and f_pc_o unchanged, no new request; after release the next request is at f_valP_i.
- Fetch jxx with valC=0x40, then assert m_mispredict_i with m_valA_i=0x5 while the request to 0x40 is outstanding: the 0x40 data is discarded and the next request is at 0x5 with f_pc_o=0x5.
- Fetch RET at 0x20: f_valid_o=0 and no requests until w_ret_i with w_valM_i=0x100; next request at 0x100.
- Fetch HALT: stat_o=1, no requests; m_mispredict_i with m_valA_i=0x8 resumes fetch at 0x8 with stat_o=0.
- Withhold ack for TIMEOUT cycles: stat_o=2, imem_req_o=0; assert rst: request at RESET_PC, stat_o=0.
